// File: rtl/spy_output_merger_if.sv
// Bus bundle between the output SpyBuffer bank, the merger and the tagged-stream consumer.
// The master modport is the merger side; the slave modport is the buffers plus consumer.
interface spy_output_merger_if #(
   parameter int unsigned DATA_WIDTH  = 256,
   parameter int unsigned N_INPUTS    = 4,
   parameter int unsigned SRC_WIDTH   = 4,
   parameter int unsigned COUNT_WIDTH = 32
);
   logic [N_INPUTS-1:0][DATA_WIDTH-1:0]  in_data;
   logic [N_INPUTS-1:0]                  in_empty;
   logic [N_INPUTS-1:0]                  in_read_enable;
   logic [DATA_WIDTH-1:0]                out_data;
   logic [SRC_WIDTH-1:0]                 out_source;
   logic                                 out_valid;
   logic                                 out_ready;
   logic [N_INPUTS-1:0][COUNT_WIDTH-1:0] word_count;
   logic                                 busy;

   modport master (
      input  in_data, in_empty, out_ready,
      output in_read_enable, out_data, out_source, out_valid, word_count, busy
   );

   modport slave (
      output in_data, in_empty, out_ready,
      input  in_read_enable, out_data, out_source, out_valid, word_count, busy
   );
endinterface

// File: rtl/spy_output_merger.sv
// Round-robin drain of N SpyBuffers into one tagged stream, with a 2-entry skid
// buffer covering the one-cycle FIFO read latency and saturating per-source counters.
module spy_output_merger #(
   parameter int unsigned DATA_WIDTH  = 256,
   parameter int unsigned N_INPUTS    = 4,
   parameter int unsigned SRC_WIDTH   = 4,
   parameter int unsigned COUNT_WIDTH = 32
) (
   input logic                 clock,
   input logic                 reset,
   spy_output_merger_if.master bus
);
   localparam int unsigned    IDX_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

   logic [IDX_W-1:0]                     last_grant;
   logic                                 inflight;
   logic [IDX_W-1:0]                     inflight_idx;
   logic [1:0]                           occupancy;
   logic [DATA_WIDTH-1:0]                head_data;
   logic [IDX_W-1:0]                     head_idx;
   logic [DATA_WIDTH-1:0]                tail_data;
   logic [IDX_W-1:0]                     tail_idx;
   logic [N_INPUTS-1:0][COUNT_WIDTH-1:0] count;

   logic                  pop;
   logic                  room;
   logic                  grant_found;
   logic [IDX_W-1:0]      grant_idx;
   logic                  issue;
   logic [N_INPUTS-1:0]   read_enable;
   logic [DATA_WIDTH-1:0] captured;

   // Issue decision: room check against in-flight plus buffered words, then round-robin search
   always_comb begin
      pop         = (occupancy != 2'd0) && bus.out_ready;
      room        = ({1'b0, occupancy} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
      grant_found = 1'b0;
      grant_idx   = last_grant;
      for (int unsigned k = 1; k <= N_INPUTS; k++) begin
         if (!grant_found && !bus.in_empty[IDX_W'((32'(last_grant) + k) % N_INPUTS)]) begin
            grant_found = 1'b1;
            grant_idx   = IDX_W'((32'(last_grant) + k) % N_INPUTS);
         end
      end
      issue       = grant_found && room && !reset;
      read_enable = '0;
      if (issue) read_enable[grant_idx] = 1'b1;
   end

   assign captured = bus.in_data[inflight_idx];

   // Arbiter state and 2-entry buffer; the head is always the oldest word
   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant   <= LAST_IDX;
         inflight     <= 1'b0;
         inflight_idx <= '0;
         occupancy    <= 2'd0;
         head_data    <= '0;
         head_idx     <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            last_grant   <= grant_idx;
            inflight_idx <= grant_idx;
         end
         case ({inflight, pop})
            2'b10: begin
               if (occupancy == 2'd0) begin
                  head_data <= captured;
                  head_idx  <= inflight_idx;
               end else begin
                  tail_data <= captured;
                  tail_idx  <= inflight_idx;
               end
               occupancy <= occupancy + 2'd1;
            end
            2'b01: begin
               if (occupancy == 2'd2) begin
                  head_data <= tail_data;
                  head_idx  <= tail_idx;
               end
               occupancy <= occupancy - 2'd1;
            end
            2'b11: begin
               if (occupancy == 2'd2) begin
                  head_data <= tail_data;
                  head_idx  <= tail_idx;
                  tail_data <= captured;
                  tail_idx  <= inflight_idx;
               end else begin
                  head_data <= captured;
                  head_idx  <= inflight_idx;
               end
            end
            default: ;
         endcase
      end
   end

   // Per-source accepted-word counters, saturating at all-ones
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else begin
         for (int unsigned i = 0; i < N_INPUTS; i++) begin
            if (pop && head_idx == IDX_W'(i) && count[i] != {COUNT_WIDTH{1'b1}}) begin
               count[i] <= count[i] + COUNT_WIDTH'(1);
            end
         end
      end
   end

   assign bus.in_read_enable = read_enable;
   assign bus.out_valid      = occupancy != 2'd0;
   assign bus.out_data       = head_data;
   assign bus.out_source     = SRC_WIDTH'(head_idx);
   assign bus.word_count     = count;
   assign bus.busy           = (occupancy != 2'd0) || inflight;

   overflow_check: assert property (@(posedge clock) disable iff (reset)
      !(inflight && !pop && occupancy == 2'd2));
endmodule

// File: tb/tb_spy_output_merger.sv
// Bench for spy_output_merger: models four SpyBuffers, keeps per-source expected-word
// queues filled at load time, and checks every accepted word plus timing corner cases.
module tb_spy_output_merger;
   localparam int unsigned DW = 64;
   localparam int unsigned NI = 4;
   localparam int unsigned SW = 4;
   localparam int unsigned CW = 4;

   typedef struct {
      logic [NI-1:0]    mask;
      int               words;
      int               len;
      logic [11:0][3:0] seq;
   } vec_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   spy_output_merger_if #(.DATA_WIDTH(DW), .N_INPUTS(NI), .SRC_WIDTH(SW), .COUNT_WIDTH(CW)) bus ();

   spy_output_merger #(.DATA_WIDTH(DW), .N_INPUTS(NI), .SRC_WIDTH(SW), .COUNT_WIDTH(CW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   int            loaded_cnt [NI];
   int            seq_up     [NI];
   int            rd_cnt     [NI];
   int            dl_cnt     [NI];
   logic [DW-1:0] exp_q      [NI][$];
   int            obs_src    [$];
   int            pop_cyc    [$];
   logic [NI-1:0] rd_mask;
   int            cyc;
   int            nrd;
   int            proto_err;
   int            tests;
   int            fails;
   vec_t          vecs [4];

   for (genvar g = 0; g < NI; g++) begin : g_empty
      assign bus.in_empty[g] = (loaded_cnt[g] == seq_up[g]);
   end

   function automatic logic [DW-1:0] mk(int s, int n);
      return {16'hC0DE, 16'(s), 32'(n)};
   endfunction

   function automatic bit pending();
      bit p = 1'b0;
      for (int i = 0; i < NI; i++) if (loaded_cnt[i] != seq_up[i]) p = 1'b1;
      return p;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic load(int s, int n);
      for (int k = 0; k < n; k++) begin
         exp_q[s].push_back(mk(s, loaded_cnt[s]));
         loaded_cnt[s]++;
      end
   endtask

   // One clock: observe at the falling edge, model the buffers at the rising edge
   task automatic tick();
      int s;
      @(negedge clock);
      rd_mask = bus.in_read_enable;
      if (((rd_mask & bus.in_empty) != '0) || !$onehot0(rd_mask)) proto_err++;
      if (reset) begin
         for (int i = 0; i < NI; i++) begin
            while (rd_cnt[i] > dl_cnt[i]) begin
               void'(exp_q[i].pop_front());
               dl_cnt[i]++;
            end
         end
      end else if (bus.out_valid && bus.out_ready) begin
         s = int'(bus.out_source);
         if (s >= NI || exp_q[s].size() == 0) begin
            check("pop_src_valid", 64'(s), 64'hFFFF);
         end else begin
            check("pop_data", 64'(bus.out_data), 64'(exp_q[s][0]));
            void'(exp_q[s].pop_front());
            dl_cnt[s]++;
            obs_src.push_back(s);
            pop_cyc.push_back(cyc);
         end
      end
      @(posedge clock);
      for (int i = 0; i < NI; i++) if (rd_mask[i]) bus.in_data[i] <= mk(i, seq_up[i]);
      #1;
      for (int i = 0; i < NI; i++) if (rd_mask[i]) begin
         seq_up[i]++;
         rd_cnt[i]++;
      end
      nrd += $countones(rd_mask);
      cyc++;
   endtask

   task automatic do_reset();
      reset         = 1'b1;
      bus.out_ready = 1'b0;
      tick();
      reset = 1'b0;
      obs_src.delete();
      pop_cyc.delete();
      nrd = 0;
   endtask

   task automatic drain(string name);
      int n = 0;
      while ((bus.busy || pending()) && n < 200) begin
         tick();
         n++;
      end
      check(name, 64'(bus.busy || pending()), 64'd0);
   endtask

   initial begin
      int c;
      int stable_err;
      logic [DW-1:0] hd;
      logic [SW-1:0] hs;
      bit seen;
      tests = 0; fails = 0; proto_err = 0; cyc = 0; nrd = 0;
      rd_mask = '0;
      for (int i = 0; i < NI; i++) begin
         loaded_cnt[i] = 0; seq_up[i] = 0; rd_cnt[i] = 0; dl_cnt[i] = 0;
      end
      bus.in_data   <= '0;
      bus.out_ready = 1'b0;
      reset         = 1'b1;

      vecs[0].mask = 4'b1111; vecs[0].words = 3; vecs[0].len = 12; vecs[0].seq = '0;
      for (int k = 0; k < 12; k++) vecs[0].seq[k] = 4'(k % 4);
      vecs[1].mask = 4'b1010; vecs[1].words = 2; vecs[1].len = 4; vecs[1].seq = '0;
      vecs[1].seq[0] = 4'd1; vecs[1].seq[1] = 4'd3; vecs[1].seq[2] = 4'd1; vecs[1].seq[3] = 4'd3;
      vecs[2].mask = 4'b0100; vecs[2].words = 1; vecs[2].len = 1; vecs[2].seq = '0;
      vecs[2].seq[0] = 4'd2;
      vecs[3].mask = 4'b1001; vecs[3].words = 2; vecs[3].len = 4; vecs[3].seq = '0;
      vecs[3].seq[0] = 4'd0; vecs[3].seq[1] = 4'd3; vecs[3].seq[2] = 4'd0; vecs[3].seq[3] = 4'd3;

      // Reset state
      tick();
      do_reset();
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_out_source", 64'(bus.out_source), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_read_enable", 64'(bus.in_read_enable), 64'd0);
      check("rst_word_count", 64'(bus.word_count), 64'd0);

      // Table-driven arbitration vectors
      for (int v = 0; v < 4; v++) begin
         do_reset();
         bus.out_ready = 1'b1;
         for (int i = 0; i < NI; i++) if (vecs[v].mask[i]) load(i, vecs[v].words);
         c = cyc;
         drain("vec_drain");
         check("vec_len", 64'(obs_src.size()), 64'(vecs[v].len));
         if (obs_src.size() == vecs[v].len) begin
            for (int k = 0; k < vecs[v].len; k++)
               check("vec_src_order", 64'(obs_src[k]), 64'(vecs[v].seq[k]));
            check("vec_fill_latency", 64'(pop_cyc[0]), 64'(c + 2));
            check("vec_no_gaps", 64'(pop_cyc[vecs[v].len-1] - pop_cyc[0]), 64'(vecs[v].len - 1));
         end
         for (int i = 0; i < NI; i++)
            check("vec_word_count", 64'(bus.word_count[i]), vecs[v].mask[i] ? 64'(vecs[v].words) : 64'd0);
      end

      // Single word timing through input 2
      do_reset();
      bus.out_ready = 1'b1;
      load(2, 1);
      tick();
      check("single_read_enable", 64'(rd_mask), 64'b0100);
      check("single_t1_valid", 64'(bus.out_valid), 64'd0);
      check("single_t1_busy", 64'(bus.busy), 64'd1);
      tick();
      check("single_t2_valid", 64'(bus.out_valid), 64'd1);
      check("single_t2_source", 64'(bus.out_source), 64'd2);
      if (exp_q[2].size() > 0) check("single_t2_data", 64'(bus.out_data), 64'(exp_q[2][0]));
      tick();
      check("single_t3_valid", 64'(bus.out_valid), 64'd0);
      check("single_t3_busy", 64'(bus.busy), 64'd0);
      check("single_count", 64'(bus.word_count[2]), 64'd1);

      // Backpressure: two reads then stall, stable head, same-cycle resume
      do_reset();
      for (int i = 0; i < NI; i++) load(i, 5);
      stable_err = 0; seen = 1'b0; hd = '0; hs = '0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (bus.out_valid) begin
            if (!seen) begin
               hd = bus.out_data; hs = bus.out_source; seen = 1'b1;
            end else if (bus.out_data !== hd || bus.out_source !== hs) begin
               stable_err++;
            end
         end
      end
      check("bp_reads", 64'(nrd), 64'd2);
      check("bp_head_seen", 64'(seen), 64'd1);
      check("bp_head_source", 64'(hs), 64'd0);
      check("bp_stable", 64'(stable_err), 64'd0);
      bus.out_ready = 1'b1;
      #1;
      check("bp_resume_same_cycle", 64'(bus.in_read_enable != '0), 64'd1);
      drain("bp_drain");
      check("bp_delivered", 64'(obs_src.size()), 64'd20);
      for (int i = 0; i < NI; i++) begin
         check("bp_word_count", 64'(bus.word_count[i]), 64'd5);
         check("bp_no_loss", 64'(exp_q[i].size()), 64'd0);
      end

      // Reset while a word is buffered and another is in flight
      do_reset();
      for (int i = 0; i < NI; i++) load(i, 6);
      bus.out_ready = 1'b1;
      repeat (6) tick();
      check("mid_busy_before", 64'(bus.busy && bus.out_valid), 64'd1);
      reset = 1'b1;
      bus.out_ready = 1'b0;
      #1;
      check("mid_re_forced_zero", 64'(bus.in_read_enable), 64'd0);
      tick();
      reset = 1'b0;
      check("mid_out_valid", 64'(bus.out_valid), 64'd0);
      check("mid_busy", 64'(bus.busy), 64'd0);
      check("mid_word_count", 64'(bus.word_count), 64'd0);
      bus.out_ready = 1'b1;
      begin
         int n = 0;
         tick();
         while (rd_mask == '0 && n < 10) begin
            tick();
            n++;
         end
      end
      check("mid_first_grant", 64'(rd_mask), 64'b0001);
      drain("mid_drain");
      for (int i = 0; i < NI; i++) check("mid_no_dup", 64'(exp_q[i].size()), 64'd0);

      // Counter saturation at 4 bits
      do_reset();
      bus.out_ready = 1'b1;
      load(0, 20);
      drain("sat_drain");
      check("sat_delivered", 64'(obs_src.size()), 64'd20);
      check("sat_count", 64'(bus.word_count[0]), 64'd15);
      check("sat_others", 64'(bus.word_count[3:1]), 64'd0);

      check("protocol_errors", 64'(proto_err), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/spy_output_merger.md
# spy_output_merger

Collects the words drained from several output SpyBuffers of a test top level and merges them into a single tagged stream for the cocotb monitor. Sits directly downstream of the output SpyBuffer bank. Pulls words using the buffers' read_enable/empty interface with round-robin fairness, absorbs the one-cycle FIFO read latency in a 2-entry output buffer, and keeps per-source word counters.

## Interface
- DATA_WIDTH, 256: width of each data word.
- N_INPUTS, 4: number of upstream SpyBuffers, 1 to 16.
- SRC_WIDTH, 4: width of the source tag; must satisfy 2^SRC_WIDTH >= N_INPUTS.
- COUNT_WIDTH, 32: width of each per-source word counter.

Ports:
- clock, input, 1: single clock for all logic.
- reset, input, 1: synchronous, active-high.
- in_data, input, N_INPUTS x DATA_WIDTH: SpyBuffer read_data, valid one cycle after the matching read enable.
- in_empty, input, N_INPUTS: SpyBuffer empty flags.
- in_read_enable, output, N_INPUTS: SpyBuffer read enables; at most one bit high per cycle.
- out_data, output, DATA_WIDTH: merged word.
- out_source, output, SRC_WIDTH: index of the input that supplied out_data.
- out_valid, output, 1: out_data and out_source are valid.
- out_ready, input, 1: consumer accepts the word when out_valid and out_ready are both high.
- word_count, output, N_INPUTS x COUNT_WIDTH: accepted words per source.
- busy, output, 1: high when out_valid is high or a read is in flight.

## Operation
- State:
  - round-robin pointer last_grant, reset value N_INPUTS-1.
  - in-flight flag and in-flight index, registered one stage.
  - 2-entry FIFO of {data, source} with occupancy 0..2.
  - counters.
- Issue rule, evaluated combinationally each cycle:
  - Let pop = out_valid & out_ready.
  - A read may be issued only if occupancy + inflight - pop < 2.
  - If a read may be issued, select the first input i with in_empty[i] low, searching from last_grant+1 upward and wrapping modulo N_INPUTS.
  - Assert in_read_enable[i], then update last_grant = i, inflight = 1, inflight_idx = i.
  - If no read is issued, inflight = 0.
- Never assert in_read_enable[i] while in_empty[i] is high. Upstream empty must update the cycle after a read.
- Capture: when inflight is high, in_data[inflight_idx] and inflight_idx are pushed into the output FIFO at the end of that cycle.
- Output:
  - out_valid = occupancy > 0.
  - out_data and out_source come from the head entry.
  - Head data and tag stay stable while out_valid is high and out_ready is low.
- Push and pop in the same cycle: occupancy is unchanged and order is preserved. The FIFO never overflows; an overflow is a design error and is asserted in simulation.
- Counters:
  - On each pop, word_count[out_source] increments by 1.
  - Counters saturate at 2^COUNT_WIDTH-1 and do not wrap.
- Reset, including mid-operation:
  - Occupancy goes to 0, inflight to 0, all counters to 0, last_grant to N_INPUTS-1.
  - Any word in flight or buffered is discarded.
  - in_read_enable is forced to all-zero during the reset cycle.
- Reset values of outputs: in_read_enable 0, out_valid 0, out_data 0, out_source 0, word_count all 0, busy 0.

## Timing
- Read latency: in_read_enable[i] high in cycle t means the word is captured at the end of t+1, and out_valid goes high in t+2 at the earliest.
- Throughput: with out_ready held high and at least one non-empty input, one word is issued and one word is delivered every cycle after the 2-cycle fill.
- Backpressure: with out_ready low, at most two reads are issued (occupancy plus in-flight reaches 2), then issue stalls. Issue resumes in the same cycle out_ready rises.
- Fairness: with k inputs continuously non-empty, each input is granted once every k issue cycles.
- busy falls the cycle after the last buffered word is popped, provided no read is in flight.

## Test plan
- Single word: after reset, in_empty[2] goes low for one word only → in_read_enable[2] pulses in cycle t, out_valid high in t+2 with out_source=2 and the same out_data, word_count[2]=1, busy low after the pop.
- Round robin: all 4 inputs hold 3 words each, out_ready=1 → sources appear in order 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles with no gaps after fill; every word_count ends at 3.
- Backpressure: out_ready=0 for 10 cycles while inputs are full → exactly 2 read enables issued; out_data and out_source are stable during the stall; when out_ready=1, the next read is issued in that same cycle and no words are lost or duplicated.
- Sparse inputs: only inputs 1 and 3 are non-empty, with last_grant=3 → grant sequence 1,3,1,3; in_read_enable[0] and in_read_enable[2] are never asserted.
- Reset mid-stream: assert reset while occupancy=2 and a read is in flight → the next cycle has out_valid=0, all counters 0, busy 0; after release, the first grant goes to input 0.
- Saturation: COUNT_WIDTH=4 with 20 words from input 0 → word_count[0] reaches 15 and holds at 15.
